// File: rtl/storage_port_arbiter.sv
// Two-requester arbiter for a single-port storage SRAM.
// Management core reads/writes, housekeeping reads; round-robin grants.
module storage_port_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mgmt_req,
  input  logic            mgmt_wen,
  input  logic [DW/8-1:0] mgmt_wen_mask,
  input  logic [AW-1:0]   mgmt_addr,
  input  logic [DW-1:0]   mgmt_wdata,
  output logic            mgmt_ack,
  output logic [DW-1:0]   mgmt_rdata,
  input  logic            hk_req,
  input  logic [AW-1:0]   hk_addr,
  output logic            hk_ack,
  output logic [DW-1:0]   hk_rdata,
  output logic            sram_ena,
  output logic            sram_wen,
  output logic [DW/8-1:0] sram_wen_mask,
  output logic [AW-1:0]   sram_addr,
  output logic [DW-1:0]   sram_wdata,
  input  logic [DW-1:0]   sram_rdata,
  output logic            busy
);

  localparam int MW = DW / 8;
  localparam int CW = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_last_b;
  logic           r_win_b;
  logic           r_is_wr;
  logic [CW-1:0]  r_cnt;
  logic           w_any;
  logic           w_grant_b;
  logic           w_to_ack;

  // hk wins when alone, or when both ask and A had the last grant
  always_comb begin
    w_any     = mgmt_req | hk_req;
    w_grant_b = hk_req & (~mgmt_req | ~r_last_b);
    w_next    = r_state;
    w_to_ack  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (RD_LAT > 1) begin
          w_next = S_WAIT;
        end else begin
          w_next   = S_ACK;
          w_to_ack = 1'b1;
        end
      end
      S_WAIT: begin
        if (r_cnt <= CW'(1)) begin
          w_next   = S_ACK;
          w_to_ack = 1'b1;
        end
      end
      S_ACK: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_b      <= 1'b0;
      r_win_b       <= 1'b0;
      r_is_wr       <= 1'b0;
      r_cnt         <= '0;
      sram_ena      <= 1'b0;
      sram_wen      <= 1'b0;
      sram_wen_mask <= '0;
      sram_addr     <= '0;
      sram_wdata    <= '0;
      mgmt_ack      <= 1'b0;
      mgmt_rdata    <= '0;
      hk_ack        <= 1'b0;
      hk_rdata      <= '0;
      busy          <= 1'b0;
    end else begin
      busy     <= (w_next != S_IDLE);
      mgmt_ack <= w_to_ack & ~r_win_b;
      hk_ack   <= w_to_ack & r_win_b;
      if (w_to_ack && r_win_b) hk_rdata <= sram_rdata;
      if (w_to_ack && !r_win_b && !r_is_wr) mgmt_rdata <= sram_rdata;

      if (r_state == S_IDLE && w_any) begin
        r_last_b <= w_grant_b;
        r_win_b  <= w_grant_b;
        r_is_wr  <= ~w_grant_b & mgmt_wen;
        sram_ena <= 1'b1;
        if (w_grant_b) begin
          sram_wen      <= 1'b0;
          sram_wen_mask <= '0;
          sram_addr     <= hk_addr;
          sram_wdata    <= '0;
        end else begin
          sram_wen      <= mgmt_wen;
          sram_wen_mask <= mgmt_wen_mask;
          sram_addr     <= mgmt_addr;
          sram_wdata    <= mgmt_wdata;
        end
      end else begin
        sram_ena      <= 1'b0;
        sram_wen      <= 1'b0;
        sram_wen_mask <= {MW{1'b0}};
        sram_addr     <= '0;
        sram_wdata    <= '0;
      end

      if (r_state == S_ISSUE) begin
        r_cnt <= CW'(RD_LAT - 1);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_storage_port_arbiter.sv
// Directed bench: one arbiter at RD_LAT=1, one at RD_LAT=3,
// each with its own SRAM model sharing one clock.
module tb_storage_port_arbiter;

  logic clk;
  logic rst1, rst2;

  logic        m1_req, m1_wen, m1_ack;
  logic [3:0]  m1_mask;
  logic [7:0]  m1_addr;
  logic [31:0] m1_wdata, m1_rdata;
  logic        h1_req, h1_ack;
  logic [7:0]  h1_addr;
  logic [31:0] h1_rdata;
  logic        s1_ena, s1_wen, busy1;
  logic [3:0]  s1_mask;
  logic [7:0]  s1_addr;
  logic [31:0] s1_wdata, s1_rdata;

  logic        m2_req, m2_wen, m2_ack;
  logic [3:0]  m2_mask;
  logic [7:0]  m2_addr;
  logic [31:0] m2_wdata, m2_rdata;
  logic        h2_req, h2_ack;
  logic [7:0]  h2_addr;
  logic [31:0] h2_rdata;
  logic        s2_ena, s2_wen, busy2;
  logic [3:0]  s2_mask;
  logic [7:0]  s2_addr;
  logic [31:0] s2_wdata, s2_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  storage_port_arbiter #(.AW(8), .DW(32), .RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(rst1),
    .mgmt_req(m1_req), .mgmt_wen(m1_wen), .mgmt_wen_mask(m1_mask),
    .mgmt_addr(m1_addr), .mgmt_wdata(m1_wdata),
    .mgmt_ack(m1_ack), .mgmt_rdata(m1_rdata),
    .hk_req(h1_req), .hk_addr(h1_addr),
    .hk_ack(h1_ack), .hk_rdata(h1_rdata),
    .sram_ena(s1_ena), .sram_wen(s1_wen), .sram_wen_mask(s1_mask),
    .sram_addr(s1_addr), .sram_wdata(s1_wdata), .sram_rdata(s1_rdata),
    .busy(busy1)
  );

  storage_port_arbiter #(.AW(8), .DW(32), .RD_LAT(3)) u_dut2 (
    .clk(clk), .reset(rst2),
    .mgmt_req(m2_req), .mgmt_wen(m2_wen), .mgmt_wen_mask(m2_mask),
    .mgmt_addr(m2_addr), .mgmt_wdata(m2_wdata),
    .mgmt_ack(m2_ack), .mgmt_rdata(m2_rdata),
    .hk_req(h2_req), .hk_addr(h2_addr),
    .hk_ack(h2_ack), .hk_rdata(h2_rdata),
    .sram_ena(s2_ena), .sram_wen(s2_wen), .sram_wen_mask(s2_mask),
    .sram_addr(s2_addr), .sram_wdata(s2_wdata), .sram_rdata(s2_rdata),
    .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM 1: data presented during the enable cycle, written at its end
  logic [31:0] mem1 [0:255];
  initial begin
    for (int i = 0; i < 256; i++) mem1[i] <= 32'hA5A50000 | i;
  end
  assign s1_rdata = s1_ena ? mem1[s1_addr] : 32'hBAD0BAD0;
  always @(posedge clk) begin
    if (s1_ena && s1_wen) begin
      for (int b = 0; b < 4; b++)
        if (s1_mask[b]) mem1[s1_addr][8*b +: 8] <= s1_wdata[8*b +: 8];
    end
  end

  // SRAM 2: read-only pattern, two extra pipeline stages
  logic [31:0] p0, p1, p2;
  assign p0 = s2_ena ? (32'hA5A50000 | {24'h0, s2_addr}) : 32'hBAD0BAD0;
  always @(posedge clk) begin
    p1 <= p0;
    p2 <= p1;
  end
  assign s2_rdata = p2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m1_access(input string tag, input logic wen,
                           input logic [3:0] mk, input logic [7:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_rd);
    m1_req = 1'b1; m1_wen = wen; m1_mask = mk; m1_addr = a; m1_wdata = wd;
    tick();
    chk($sformatf("%s/issue", tag),
        {s1_ena, s1_wen, s1_mask, s1_addr, s1_wdata, m1_ack, busy1},
        {1'b1, wen, mk, a, wd, 1'b0, 1'b1});
    tick();
    chk($sformatf("%s/ack", tag),
        {m1_ack, h1_ack, s1_ena, busy1, m1_rdata},
        {1'b1, 1'b0, 1'b0, 1'b1, exp_rd});
    m1_req = 1'b0;
    tick();
    chk($sformatf("%s/idle", tag), {m1_ack, busy1, s1_ena}, 3'b000);
  endtask

  task automatic d2_run(input bit hk, input logic [7:0] a,
                        output int nb, output int at, output int na,
                        output logic [31:0] rd);
    nb = 0; at = -1; na = 0; rd = '0;
    if (hk) begin
      h2_req = 1'b1; h2_addr = a;
    end else begin
      m2_req = 1'b1; m2_wen = 1'b0; m2_mask = 4'h0; m2_addr = a;
      m2_wdata = '0;
    end
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (busy2) nb++;
      if ((hk && m2_ack) || (!hk && h2_ack)) na += 100;
      if ((hk && h2_ack) || (!hk && m2_ack)) begin
        na++;
        if (at < 0) at = t;
        rd = hk ? h2_rdata : m2_rdata;
        m2_req = 1'b0;
        h2_req = 1'b0;
      end
    end
    m2_req = 1'b0;
    h2_req = 1'b0;
  endtask

  int nb, at, na;
  logic [31:0] rd;

  initial begin
    rst1 = 1'b1; rst2 = 1'b1;
    m1_req = 0; m1_wen = 0; m1_mask = 0; m1_addr = 0; m1_wdata = 0;
    h1_req = 0; h1_addr = 0;
    m2_req = 0; m2_wen = 0; m2_mask = 0; m2_addr = 0; m2_wdata = 0;
    h2_req = 0; h2_addr = 0;

    tick(); tick();
    chk("reset1", {s1_ena, s1_wen, s1_mask, s1_addr, s1_wdata, m1_ack,
                   m1_rdata, h1_ack, h1_rdata, busy1}, '0);
    chk("reset2", {s2_ena, s2_wen, s2_mask, s2_addr, s2_wdata, m2_ack,
                   m2_rdata, h2_ack, h2_rdata, busy2}, '0);
    rst1 = 1'b0; rst2 = 1'b0;
    tick();
    chk("idle1", {s1_ena, m1_ack, h1_ack, busy1}, 4'h0);

    m1_access("wr12", 1'b1, 4'hF, 8'h12, 32'hDEADBEEF, 32'h0);
    m1_access("rd12", 1'b0, 4'h0, 8'h12, 32'h0, 32'hDEADBEEF);
    m1_access("wr05", 1'b1, 4'hF, 8'h05, 32'hFFFFFFFF, 32'hDEADBEEF);
    m1_access("wr05m", 1'b1, 4'h2, 8'h05, 32'h00000000, 32'hDEADBEEF);
    m1_access("rd05", 1'b0, 4'h0, 8'h05, 32'h0, 32'hFFFF00FF);
    m1_access("wr05z", 1'b1, 4'h0, 8'h05, 32'h12345678, 32'hFFFF00FF);
    m1_access("rd05b", 1'b0, 4'h0, 8'h05, 32'h0, 32'hFFFF00FF);
    m1_access("rdFF", 1'b0, 4'h0, 8'hFF, 32'h0, 32'hA5A500FF);

    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    m1_req = 1; m1_wen = 0; m1_mask = 4'hF; m1_addr = 8'h01;
    m1_wdata = 32'hFFFFFFFF;
    h1_req = 1; h1_addr = 8'h02;
    tick();
    chk("sim/hk_issue", {s1_ena, s1_wen, s1_mask, s1_addr, s1_wdata},
        {1'b1, 1'b0, 4'h0, 8'h02, 32'h0});
    tick();
    chk("sim/hk_ack", {h1_ack, m1_ack, h1_rdata}, {1'b1, 1'b0, 32'hA5A50002});
    h1_req = 0;
    tick();
    chk("sim/gap", {h1_ack, m1_ack, busy1, s1_ena}, 4'h0);
    tick();
    chk("sim/m_issue", {s1_ena, s1_wen, s1_mask, s1_addr, s1_wdata},
        {1'b1, 1'b0, 4'hF, 8'h01, 32'hFFFFFFFF});
    tick();
    chk("sim/m_ack", {m1_ack, h1_ack, m1_rdata, h1_rdata},
        {1'b1, 1'b0, 32'hA5A50001, 32'hA5A50002});
    m1_req = 0;
    tick();

    // both held: last grant was A, so B first, then alternate
    m1_req = 1; m1_wen = 0; m1_mask = 0; m1_addr = 8'h20; m1_wdata = 0;
    h1_req = 1; h1_addr = 8'h10;
    for (int g = 0; g < 20; g++) begin
      tick();
      chk($sformatf("rr%0d/issue", g), {s1_ena, s1_addr},
          {1'b1, (g % 2 == 0) ? 8'h10 : 8'h20});
      tick();
      if (g % 2 == 0)
        chk($sformatf("rr%0d/ack", g), {m1_ack, h1_ack, h1_rdata},
            {1'b0, 1'b1, 32'hA5A50010});
      else
        chk($sformatf("rr%0d/ack", g), {m1_ack, h1_ack, m1_rdata},
            {1'b1, 1'b0, 32'hA5A50020});
      if (g == 19) begin
        m1_req = 0; h1_req = 0;
      end
      tick();
    end
    tick();
    chk("rr/end", {m1_ack, h1_ack, busy1, s1_ena}, 4'h0);

    d2_run(1'b0, 8'h33, nb, at, na, rd);
    chk("lat3/m_busy", nb, 4);
    chk("lat3/m_ackt", at, 4);
    chk("lat3/m_acks", na, 1);
    chk("lat3/m_data", rd, 32'hA5A50033);

    d2_run(1'b1, 8'h34, nb, at, na, rd);
    chk("lat3/h_busy", nb, 4);
    chk("lat3/h_ackt", at, 4);
    chk("lat3/h_acks", na, 1);
    chk("lat3/h_data", rd, 32'hA5A50034);

    m2_req = 1; m2_wen = 0; m2_mask = 0; m2_addr = 8'h40;
    tick();
    tick();
    chk("rstw/inwait", {busy2, s2_ena, m2_ack}, 3'b100);
    rst2 = 1'b1;
    m2_req = 0;
    #1;
    chk("rstw/zero", {s2_ena, s2_wen, s2_mask, s2_addr, s2_wdata, m2_ack,
                      m2_rdata, h2_ack, h2_rdata, busy2}, '0);
    tick();
    rst2 = 1'b0;
    na = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (m2_ack || h2_ack || busy2) na++;
    end
    chk("rstw/noack", na, 0);

    d2_run(1'b0, 8'h41, nb, at, na, rd);
    chk("rstw/next_ackt", at, 4);
    chk("rstw/next_acks", na, 1);
    chk("rstw/next_data", rd, 32'hA5A50041);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/storage_port_arbiter.md
Name: storage_port_arbiter

Overview:
- Shares one single-port storage SRAM block between two requesters.
- Requester A is the management core; it can read and write.
- Requester B is the housekeeping SPI; it is read-only.
- The block sits between mgmt_core / housekeeping and one storage RAM block. It serialises accesses with a fixed-latency FSM and round-robin arbitration, and returns registered read data with a one-cycle ack.

Parameters:
- AW, 8: address width (words).
- DW, 32: data width; must be a multiple of 8.
- RD_LAT, 1: SRAM read latency in cycles; legal range 1..4.

Ports:
- clk  input  1  single clock for all logic.
- reset  input  1  asynchronous, active-high reset.
- mgmt_req  input  1  management access request; held until ack.
- mgmt_wen  input  1  1 = write, 0 = read.
- mgmt_wen_mask  input  DW/8  byte write mask.
- mgmt_addr  input  AW  word address.
- mgmt_wdata  input  DW  write data.
- mgmt_ack  output  1  one-cycle completion pulse.
- mgmt_rdata  output  DW  registered read data.
- hk_req  input  1  housekeeping read request; held until ack.
- hk_addr  input  AW  word address.
- hk_ack  output  1  one-cycle completion pulse.
- hk_rdata  output  DW  registered read data.
- sram_ena  output  1  SRAM enable.
- sram_wen  output  1  SRAM write enable.
- sram_wen_mask  output  DW/8  SRAM byte mask.
- sram_addr  output  AW  SRAM address.
- sram_wdata  output  DW  SRAM write data.
- sram_rdata  input  DW  SRAM read data, valid RD_LAT cycles after the ena cycle.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset values:
  - All outputs 0: sram_* 0, both acks 0, both rdata 0, busy 0.
  - FSM = IDLE; last_grant = A; wait counter = 0.
- Clocking: all outputs are registered; there is no combinational path from inputs to outputs.
- FSM states are IDLE, ISSUE, WAIT, ACK.
- IDLE (cycle N):
  - Samples both req lines.
  - If neither is high, stay in IDLE with sram_ena=0.
  - Otherwise choose a winner and register its command into sram_* with sram_ena=1, then go to ISSUE.
  - For an hk grant: sram_wen=0, sram_wen_mask=0, sram_wdata=0.
- Arbitration:
  - If only one requester is high, it wins.
  - If both are high, the requester opposite to last_grant wins.
  - last_grant updates on every grant.
  - Since last_grant resets to A, the first simultaneous request goes to hk (B).
- ISSUE (cycle N+1):
  - sram_ena is high for exactly this cycle; all sram_* outputs return to 0 at the next edge.
  - Load the wait counter with RD_LAT-1.
  - Go to WAIT if RD_LAT>1, otherwise to ACK.
- WAIT:
  - Decrement the counter each cycle; go to ACK when it reaches 0.
  - Writes traverse the same states, so read and write latency are identical.
- ACK:
  - Entered on the edge where sram_rdata is valid (N+1+RD_LAT).
  - At that edge, capture sram_rdata into the winner's rdata register (reads only) and set the winner's ack.
  - The ack is high for exactly one cycle: cycle N+2 at RD_LAT=1. Then return to IDLE.
- Latency: for RD_LAT=1, ack is asserted 2 cycles after the request is sampled in IDLE.
  - Minimum spacing between grants is RD_LAT+2 cycles.
- rdata retention:
  - mgmt_rdata and hk_rdata hold their value until the next read ack to the same requester.
  - A write ack leaves mgmt_rdata unchanged.
- Requester rules:
  - Inputs must stay stable while req is high.
  - req must be low in the cycle after ack.
  - IDLE re-samples req in that cycle, so a requester that fails to drop req has it treated as a new request.
- Loser handling: the losing requester stays pending and is granted next. This guarantees worst-case wait of one foreign access, i.e. no starvation.
- Write mask: mgmt_wen=1 with mgmt_wen_mask=0 is still issued and acked; the SRAM performs no byte writes.
- busy: high in ISSUE, WAIT and ACK.
- Reset mid-operation: FSM goes to IDLE immediately, the in-flight ack is suppressed and the access is lost; the requester re-issues it.
- Address: passed through unchanged; no range check, wraps naturally at 2^AW.

Test Plan:
- Single mgmt write then read: write addr 0x12 data 0xDEADBEEF mask 0xF, then read 0x12.
  - Each ack comes 2 cycles after its IDLE sample (RD_LAT=1), and mgmt_rdata = 0xDEADBEEF.
  - sram_ena is one cycle wide per access.
- Byte mask: write 0xFFFFFFFF to 0x05, then write 0x00000000 with mask 0x2, then read.
  - Read returns 0xFFFF00FF.
- Simultaneous requests out of reset: mgmt read 0x01 and hk read 0x02 in the same cycle.
  - hk acked first, mgmt acked 3 cycles later; each rdata holds its own word.
- Starvation check: mgmt and hk both held continuously for 20 accesses.
  - Grants alternate B, A, B, A…; neither requester goes more than one access without a grant.
- Latency parameter: RD_LAT=3 with an SRAM model of 3-cycle latency.
  - Ack 4 cycles after sampling; correct data; busy high for exactly 4 cycles.
- Reset in WAIT: assert reset during WAIT (RD_LAT=3).
  - No ack is ever produced, all outputs read 0, and the next request completes normally.
